master_loop_sequencer: RTL

MASTER_LOOP_SEQUENCER -- requirements
Module: master_loop_sequencer

---
 rtl/master_loop_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/master_loop_sequencer.sv
// Loop sequencer: issues cfg_count iterations starting at cfg_first with a fixed stride,
// with per-iteration timeout, bounded re-issue and abort handling.
module master_loop_sequencer #(
    parameter int IDX_W     = 5,
    parameter int TMO_W     = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W-1:0] cfg_first,
    input  logic [IDX_W-1:0] cfg_count,
    input  logic [IDX_W-1:0] cfg_stride,
    input  logic [TMO_W-1:0] cfg_timeout,
    output logic             iter_start,
    output logic [IDX_W-1:0] iter_idx,
    input  logic             iter_done,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [IDX_W-1:0] iters_done
);

    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_TMO   = 2'b01;
    localparam logic [1:0] ERR_ABORT = 2'b10;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] stride_q, stride_d;
    logic [IDX_W-1:0] iters_q, iters_d;
    logic [TMO_W-1:0] tmo_cfg_q, tmo_cfg_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [1:0]       err_q, err_d;
    logic             iter_start_q, iter_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        count_d   = count_q;
        stride_d  = stride_q;
        iters_d   = iters_q;
        tmo_cfg_d = tmo_cfg_q;
        tmo_d     = tmo_q;
        retry_d   = retry_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d     = cfg_first;
                    count_d   = cfg_count;
                    stride_d  = cfg_stride;
                    tmo_cfg_d = cfg_timeout;
                    iters_d   = '0;
                    err_d     = ERR_NONE;
                    retry_d   = '0;
                    state_d   = (cfg_count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    err_d   = ERR_ABORT;
                    state_d = ERR;
                end else begin
                    tmo_d   = tmo_cfg_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Priority: abort, then completion, then timeout expiry.
                if (abort) begin
                    err_d   = ERR_ABORT;
                    state_d = ERR;
                end else if (iter_done) begin
                    iters_d = iters_q + IDX_W'(1);
                    retry_d = '0;
                    idx_d   = idx_q + stride_q;
                    tmo_d   = '0;
                    state_d = (iters_q + IDX_W'(1) == count_q) ? DONE : ISSUE;
                end else if (tmo_cfg_q != '0) begin
                    if (tmo_q <= TMO_W'(1)) begin
                        tmo_d = '0;
                        if (retry_q < RTY_MAX) begin
                            retry_d = retry_q + RTY_W'(1);
                            state_d = ISSUE;
                        end else begin
                            err_d   = ERR_TMO;
                            state_d = ERR;
                        end
                    end else begin
                        tmo_d = tmo_q - TMO_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pulses are registered from the next state so they align with the state they flag.
        iter_start_d = (state_d == ISSUE);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
        error_d      = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            count_q      <= '0;
            stride_q     <= '0;
            iters_q      <= '0;
            tmo_cfg_q    <= '0;
            tmo_q        <= '0;
            retry_q      <= '0;
            err_q        <= ERR_NONE;
            iter_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            stride_q     <= stride_d;
            iters_q      <= iters_d;
            tmo_cfg_q    <= tmo_cfg_d;
            tmo_q        <= tmo_d;
            retry_q      <= retry_d;
            err_q        <= err_d;
            iter_start_q <= iter_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign iter_start = iter_start_q;
    assign iter_idx   = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = err_q;
    assign iters_done = iters_q;

endmodule
